// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } fetch_state_e;

    localparam int INSTR_BYTES = 4;

endpackage
`default_nettype wire

// File: rtl/if_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_unit_if
// Description : Instruction-memory request/response and IF/ID handshake bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface if_fetch_unit_if #(
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32
);
    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [ADDR_W-1:0]  imem_req_addr;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;
    logic               if_valid;
    logic               if_ready;
    logic [ADDR_W-1:0]  if_pc;
    logic [INSTR_W-1:0] if_instr;

    // Fetch unit side
    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output if_valid, if_pc, if_instr,
        input  if_ready
    );

    // Memory + decode side
    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  if_valid, if_pc, if_instr,
        output if_ready
    );
endinterface
`default_nettype wire

// File: rtl/fetch_out_reg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_out_reg
// Description : IF/ID holding register with valid/ready drain, load and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_out_reg #(
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32
) (
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic               i_load,
    input  wire logic               i_flush,
    input  wire logic               i_ready,
    input  wire logic [ADDR_W-1:0]  i_pc,
    input  wire logic [INSTR_W-1:0] i_instr,
    output logic                    o_valid,
    output logic [ADDR_W-1:0]       o_pc,
    output logic [INSTR_W-1:0]      o_instr
);

    logic               valid_q, valid_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;

    // Flush wins over load; a load on the draining edge keeps the entry valid.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (i_flush) begin
            valid_d = 1'b0;
        end else if (i_load) begin
            valid_d = 1'b1;
            pc_d    = i_pc;
            instr_d = i_instr;
        end else if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign o_valid = valid_q;
    assign o_pc    = pc_q;
    assign o_instr = instr_q;

endmodule
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_unit
// Description : PC owner and instruction fetcher, one outstanding read at most.
//               Optional MISALIGN_TRAP_EN: sticky fault on misaligned redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 64,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              redirect_valid,
    input  wire logic [ADDR_W-1:0] redirect_pc,
    if_fetch_unit_if.master        bus,
    output logic                   fetch_fault
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              if_free;
    logic              req_valid;
    logic              req_hs;
    logic              load;
    logic              fault_d;
    logic              fault_q;

    assign if_free = !bus.if_valid || bus.if_ready;
    assign req_hs  = req_valid && bus.imem_req_ready;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_comb begin
        fault_d = fault_q || (redirect_valid && (redirect_pc[1:0] != 2'b00));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end
`else
    assign fault_d = 1'b0;
    assign fault_q = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Next-state and PC update
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        load    = 1'b0;
        if (redirect_valid) begin
            pc_d = redirect_pc;
            unique case (state_q)
                IDLE:    state_d = REQ;
                REQ:     state_d = req_hs ? DROP : REQ;
                // A response arriving with the redirect is stale and consumed here.
                WAIT:    state_d = bus.imem_rsp_valid ? REQ : DROP;
                DROP:    state_d = bus.imem_rsp_valid ? REQ : DROP;
                default: state_d = IDLE;
            endcase
        end else begin
            unique case (state_q)
                IDLE:    state_d = REQ;
                REQ:     state_d = req_hs ? WAIT : REQ;
                WAIT: begin
                    if (bus.imem_rsp_valid) begin
                        load    = 1'b1;
                        pc_d    = pc_q + ADDR_W'(INSTR_BYTES);
                        state_d = REQ;
                    end
                end
                DROP:    state_d = bus.imem_rsp_valid ? REQ : DROP;
                default: state_d = IDLE;
            endcase
        end
        // Once faulted, the unit parks instead of issuing further requests.
        if (fault_d && (state_d == REQ)) begin
            state_d = IDLE;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    always_comb begin
        req_valid = 1'b0;
        if (state_q == REQ) begin
            req_valid = if_free;
        end
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc_q;
    assign fetch_fault        = fault_q;

    fetch_out_reg #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_out_reg (
        .clk     (clk),
        .reset   (reset),
        .i_load  (load),
        .i_flush (redirect_valid),
        .i_ready (bus.if_ready),
        .i_pc    (pc_q),
        .i_instr (bus.imem_rsp_data),
        .o_valid (bus.if_valid),
        .o_pc    (bus.if_pc),
        .o_instr (bus.if_instr)
    );

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_unit
// Description : Randomized scoreboard bench for if_fetch_unit with a memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_unit;

    localparam int          ADDR_W   = 64;
    localparam int          INSTR_W  = 32;
    localparam logic [63:0] RESET_PC = 64'h0;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        fetch_fault;

    if_fetch_unit_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus_if ();

    if_fetch_unit #(
        .ADDR_W   (ADDR_W),
        .INSTR_W  (INSTR_W),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (bus_if),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    typedef struct { logic [63:0] pc; logic [31:0] instr; } item_t;
    typedef struct { int unsigned due; logic [31:0] data; } rsp_t;

    item_t       exp_q[$];
    rsp_t        pend[$];
    logic [63:0] exp_addr_q[$];

    int          n_cmp = 0;
    int          n_fail = 0;
    int unsigned cyc = 0;
    int          consumed = 0;
    bit          beef_seen = 1'b0;
    int          req_ready_pct = 100;
    int          if_ready_pct = 100;
    int          redir_pct = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    bit          want_redirect = 1'b0;
    logic [63:0] want_target = '0;
    bit          acc_flag = 1'b0;
    bit          prev_req_stall = 1'b0;
    logic [63:0] prev_req_addr = '0;
    bit          hold_prev = 1'b0;
    logic [63:0] hold_pc = '0;
    logic [31:0] hold_instr = '0;

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_f(input logic [63:0] a);
        logic [31:0] lo;
        lo = a[31:0] * 32'h9E3779B1;
        return lo ^ a[63:32] ^ 32'h5A5A0F0F;
    endfunction

    function automatic item_t mk(input logic [63:0] pc);
        item_t it;
        it.pc    = pc;
        it.instr = mem_f(pc);
        return it;
    endfunction

    function automatic logic [63:0] rand_target();
        logic [63:0] t;
        case ($urandom_range(2))
            0:       t = {32'h0, $urandom};
            1:       t = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15));
            default: t = {$urandom, $urandom};
        endcase
        return t & ~64'h3;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic sb_reset(input logic [63:0] pc);
        exp_q.delete();
        exp_q.push_back(mk(pc));
    endtask

    // One clock: drive at negedge, observe requests, apply redirects to the model.
    task automatic cycle();
        int unsigned lat;
        rsp_t        r;
        @(negedge clk);
        cyc++;
        bus_if.imem_req_ready = ($urandom_range(99) < req_ready_pct);
        bus_if.if_ready       = ($urandom_range(99) < if_ready_pct);
        bus_if.imem_rsp_valid = 1'b0;
        bus_if.imem_rsp_data  = $urandom;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            r = pend.pop_front();
            bus_if.imem_rsp_valid = 1'b1;
            bus_if.imem_rsp_data  = r.data;
        end
        redirect_valid = 1'b0;
        if (want_redirect) begin
            redirect_valid = 1'b1;
            redirect_pc    = want_target;
            want_redirect  = 1'b0;
        end else if (reset && ($urandom_range(99) < redir_pct)) begin
            redirect_valid = 1'b1;
            redirect_pc    = rand_target();
        end
        #1;
        acc_flag = 1'b0;
        if (reset) begin
            if (prev_req_stall) begin
                check("req_valid_held", 64'(bus_if.imem_req_valid), 64'd1);
                check("req_addr_stable", bus_if.imem_req_addr, prev_req_addr);
            end
            if (bus_if.imem_req_valid && bus_if.imem_req_ready) begin
                acc_flag = 1'b1;
                lat      = $urandom_range(lat_max, lat_min);
                r.due    = cyc + lat;
                r.data   = mem_f(bus_if.imem_req_addr);
                pend.push_back(r);
                if (exp_addr_q.size() > 0)
                    check("req_addr", bus_if.imem_req_addr, exp_addr_q.pop_front());
            end
            prev_req_stall = bus_if.imem_req_valid && !bus_if.imem_req_ready && !redirect_valid;
            prev_req_addr  = bus_if.imem_req_addr;
        end else begin
            prev_req_stall = 1'b0;
        end
        @(posedge clk);
        #1;
        if (redirect_valid && reset) sb_reset(redirect_pc);
    endtask

    task automatic wait_accept(input string name);
        int n = 0;
        do begin
            cycle();
            n++;
        end while (!acc_flag && n < 50);
        check({name, "_accept_seen"}, 64'(acc_flag), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_if_valid"},  64'(bus_if.if_valid), 64'd0);
        check({tag, "_req_valid"}, 64'(bus_if.imem_req_valid), 64'd0);
        check({tag, "_fault"},     64'(fetch_fault), 64'd0);
        check({tag, "_if_pc"},     bus_if.if_pc, 64'd0);
        check({tag, "_if_instr"},  64'(bus_if.if_instr), 64'd0);
    endtask

    // Monitor: scoreboard pop on every decode handshake, plus hold rules.
    initial begin : monitor
        item_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                hold_prev = 1'b0;
                continue;
            end
            if (bus_if.if_valid && bus_if.if_instr == 32'hDEADBEEF) beef_seen = 1'b1;
            if (hold_prev) begin
                check("if_held_valid", 64'(bus_if.if_valid), 64'd1);
                check("if_held_pc", bus_if.if_pc, hold_pc);
                check("if_held_instr", 64'(bus_if.if_instr), 64'(hold_instr));
            end
            if (bus_if.if_valid && !bus_if.if_ready)
                check("req_blocked", 64'(bus_if.imem_req_valid), 64'd0);
            if (bus_if.if_valid && bus_if.if_ready) begin
                consumed++;
                if (exp_q.size() == 0) begin
                    check("sb_nonempty", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("if_pc", bus_if.if_pc, e.pc);
                    check("if_instr", 64'(bus_if.if_instr), 64'(e.instr));
                    exp_q.push_back(mk(e.pc + 64'd4));
                end
            end
            hold_prev  = bus_if.if_valid && !bus_if.if_ready && !redirect_valid;
            hold_pc    = bus_if.if_pc;
            hold_instr = bus_if.if_instr;
        end
    end

    initial begin : stim
        rsp_t r;
        int   c0;
        int   n_acc;
        reset                 = 1'b0;
        redirect_valid        = 1'b0;
        redirect_pc           = '0;
        bus_if.imem_req_ready = 1'b0;
        bus_if.if_ready       = 1'b0;
        bus_if.imem_rsp_valid = 1'b0;
        bus_if.imem_rsp_data  = '0;
        sb_reset(RESET_PC);
        repeat (2) cycle();
        check_reset_outputs("rst");

        // Sequential fetch from RESET_PC with zero-wait memory
        exp_addr_q.push_back(64'd0);
        exp_addr_q.push_back(64'd4);
        exp_addr_q.push_back(64'd8);
        exp_addr_q.push_back(64'd12);
        reset = 1'b1;
        repeat (20) cycle();
        check("seq_addrs_seen", 64'(exp_addr_q.size()), 64'd0);

        // Decode stall with an entry held
        c0 = 0;
        while (!bus_if.if_valid && c0 < 30) begin
            cycle();
            c0++;
        end
        if_ready_pct = 0;
        repeat (5) begin
            cycle();
            check("stall_if_valid", 64'(bus_if.if_valid), 64'd1);
            check("stall_req_valid", 64'(bus_if.imem_req_valid), 64'd0);
        end
        if_ready_pct = 100;
        repeat (12) cycle();

        // Redirect in WAIT; stale response arrives later
        lat_min = 4; lat_max = 4;
        repeat (6) cycle();
        wait_accept("wait_redir");
        if (pend.size() > 0) begin
            r      = pend.pop_back();
            r.data = 32'hDEADBEEF;
            pend.push_back(r);
        end
        beef_seen = 1'b0;
        exp_addr_q.push_back(64'h100);
        want_redirect = 1'b1;
        want_target   = 64'h100;
        repeat (14) cycle();
        check("wait_redir_addr_seen", 64'(exp_addr_q.size()), 64'd0);
        check("stale_never_visible", 64'(beef_seen), 64'd0);

        // Redirect coinciding with the response
        lat_min = 1; lat_max = 1;
        repeat (6) cycle();
        wait_accept("rsp_redir");
        exp_addr_q.push_back(64'h200);
        want_redirect = 1'b1;
        want_target   = 64'h200;
        cycle();
        check("rsp_redir_if_valid0", 64'(bus_if.if_valid), 64'd0);
        cycle();
        check("rsp_redir_if_valid1", 64'(bus_if.if_valid), 64'd0);
        repeat (10) cycle();
        check("rsp_redir_addr_seen", 64'(exp_addr_q.size()), 64'd0);

        // PC wrap at the top of the address space
        lat_min = 3; lat_max = 3;
        repeat (6) cycle();
        wait_accept("wrap");
        exp_addr_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);
        exp_addr_q.push_back(64'h0);
        exp_addr_q.push_back(64'h4);
        want_redirect = 1'b1;
        want_target   = 64'hFFFF_FFFF_FFFF_FFFC;
        repeat (24) cycle();
        check("wrap_addrs_seen", 64'(exp_addr_q.size()), 64'd0);

        // Asynchronous reset in the middle of WAIT
        lat_min = 4; lat_max = 4;
        repeat (6) cycle();
        wait_accept("mid_rst");
        cycle();
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        pend.delete();
        exp_addr_q.delete();
        sb_reset(RESET_PC);
        repeat (2) cycle();
        reset = 1'b1;
        exp_addr_q.push_back(RESET_PC);
        exp_addr_q.push_back(RESET_PC + 64'd4);
        repeat (14) cycle();
        check("restart_addrs_seen", 64'(exp_addr_q.size()), 64'd0);

        // Randomized traffic with redirects
        req_ready_pct = 70; if_ready_pct = 70; redir_pct = 4;
        lat_min = 1; lat_max = 5;
        repeat (3000) cycle();

`ifdef MISALIGN_TRAP_EN
        redir_pct = 0; req_ready_pct = 100; if_ready_pct = 100;
        lat_min = 4; lat_max = 4;
        repeat (10) cycle();
        wait_accept("misalign");
        want_redirect = 1'b1;
        want_target   = 64'h102;
        cycle();
        check("misalign_fault", 64'(fetch_fault), 64'd1);
        n_acc = 0;
        repeat (20) begin
            cycle();
            if (bus_if.imem_req_valid || acc_flag) n_acc++;
        end
        check("misalign_no_req", 64'(n_acc), 64'd0);
        check("misalign_if_valid", 64'(bus_if.if_valid), 64'd0);
        check("misalign_fault_sticky", 64'(fetch_fault), 64'd1);
        reset = 1'b0;
        #1;
        check_reset_outputs("misalign_rst");
        pend.delete();
        sb_reset(RESET_PC);
        repeat (2) cycle();
        reset = 1'b1;
`else
        n_acc = 0;
`endif

        // Drain with an ideal memory and decode: forward progress expected
        redir_pct = 0; req_ready_pct = 100; if_ready_pct = 100;
        lat_min = 1; lat_max = 1;
        repeat (12) cycle();
        c0 = consumed;
        repeat (60) cycle();
        check("drain_progress", 64'((consumed - c0) >= 15), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
